// File: rtl/rr_grant_arbiter.sv
// Round-robin arbiter: registered one-hot grant held under a valid/ready
// handshake; the pointer moves past each accepted winner so nobody starves.
module rr_grant_arbiter #(
    parameter int NUM_REQ = 8,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [NUM_REQ-1:0] req_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [IDX_W-1:0]   gnt_idx_o,
    output logic               gnt_valid_o,
    input  logic               gnt_ready_i,
    output logic [IDX_W-1:0]   ptr_o
);

    typedef enum logic {S_IDLE = 1'b0, S_GRANT = 1'b1} state_t;

    state_t             r_state, w_state_n;
    logic [NUM_REQ-1:0] r_gnt, w_gnt_n, w_win_oh;
    logic [IDX_W-1:0]   r_idx, w_idx_n;
    logic [IDX_W-1:0]   r_ptr, w_ptr_n;
    logic [IDX_W-1:0]   w_ptr_inc, w_sel_ptr;
    logic [IDX_W-1:0]   w_lo_all, w_lo_msk, w_win;
    logic               w_any, w_msk_hit;

    // At a handshake the next winner is picked against the advanced pointer,
    // which is what makes back-to-back grants rotate without a bubble.
    assign w_ptr_inc = (r_idx == IDX_W'(NUM_REQ - 1)) ? '0 : r_idx + 1'b1;
    assign w_sel_ptr = (r_state == S_GRANT) ? w_ptr_inc : r_ptr;

    // Descending scan: the last hit written is the lowest set index.
    always_comb begin
        w_lo_all  = '0;
        w_lo_msk  = '0;
        w_msk_hit = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_i[k]) begin
                w_lo_all = IDX_W'(k);
                if (IDX_W'(k) >= w_sel_ptr) begin
                    w_lo_msk  = IDX_W'(k);
                    w_msk_hit = 1'b1;
                end
            end
        end
    end

    assign w_any    = |req_i;
    assign w_win    = w_msk_hit ? w_lo_msk : w_lo_all;
    assign w_win_oh = {{(NUM_REQ-1){1'b0}}, 1'b1} << w_win;

    always_comb begin
        w_state_n = r_state;
        w_gnt_n   = r_gnt;
        w_idx_n   = r_idx;
        w_ptr_n   = r_ptr;
        case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    w_state_n = S_GRANT;
                    w_gnt_n   = w_win_oh;
                    w_idx_n   = w_win;
                end
            end
            S_GRANT: begin
                if (gnt_ready_i) begin
                    w_ptr_n = w_ptr_inc;
                    if (w_any) begin
                        w_gnt_n = w_win_oh;
                        w_idx_n = w_win;
                    end else begin
                        w_state_n = S_IDLE;
                        w_gnt_n   = '0;
                    end
                end
            end
            default: begin
                w_state_n = S_IDLE;
                w_gnt_n   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_gnt   <= '0;
            r_idx   <= '0;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_n;
            r_gnt   <= w_gnt_n;
            r_idx   <= w_idx_n;
            r_ptr   <= w_ptr_n;
        end
    end

    assign gnt_o       = r_gnt;
    assign gnt_idx_o   = r_idx;
    assign gnt_valid_o = (r_state == S_GRANT);
    assign ptr_o       = r_ptr;

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// Directed bench for rr_grant_arbiter: a 4-requester and a 5-requester instance
// share clock and reset; expected values are hand-computed constants.
module tb_rr_grant_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req4 = '0;
    logic [3:0] gnt4;
    logic [1:0] idx4, ptr4;
    logic       vld4;
    logic       rdy4 = 1'b0;
    logic [4:0] req5 = '0;
    logic [4:0] gnt5;
    logic [2:0] idx5, ptr5;
    logic       vld5;
    logic       rdy5 = 1'b0;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    rr_grant_arbiter #(.NUM_REQ(4)) u_dut4 (
        .clk_i(clk), .rst_i(rst), .req_i(req4), .gnt_o(gnt4), .gnt_idx_o(idx4),
        .gnt_valid_o(vld4), .gnt_ready_i(rdy4), .ptr_o(ptr4)
    );

    rr_grant_arbiter #(.NUM_REQ(5)) u_dut5 (
        .clk_i(clk), .rst_i(rst), .req_i(req5), .gnt_o(gnt5), .gnt_idx_o(idx5),
        .gnt_valid_o(vld5), .gnt_ready_i(rdy5), .ptr_o(ptr5)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk4(input string tag, input logic v, input logic [3:0] g,
                        input logic [1:0] i, input logic [1:0] p);
        check({tag, ".valid"}, {31'd0, vld4}, {31'd0, v});
        check({tag, ".gnt"},   {28'd0, gnt4}, {28'd0, g});
        if (v) check({tag, ".idx"}, {30'd0, idx4}, {30'd0, i});
        check({tag, ".ptr"},   {30'd0, ptr4}, {30'd0, p});
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        // reset state and idle with no requests
        do_reset();
        chk4("rst", 1'b0, 4'b0000, 2'd0, 2'd0);
        check("rst.idx", {30'd0, idx4}, 32'd0);
        for (int c = 0; c < 5; c++) begin
            step();
            chk4("idle", 1'b0, 4'b0000, 2'd0, 2'd0);
        end

        // full request with ready held high: one grant per cycle, rotating
        do_reset();
        req4 = 4'b1111;
        rdy4 = 1'b1;
        step(); chk4("rr0", 1'b1, 4'b0001, 2'd0, 2'd0);
        step(); chk4("rr1", 1'b1, 4'b0010, 2'd1, 2'd1);
        step(); chk4("rr2", 1'b1, 4'b0100, 2'd2, 2'd2);
        step(); chk4("rr3", 1'b1, 4'b1000, 2'd3, 2'd3);
        step(); chk4("rr4", 1'b1, 4'b0001, 2'd0, 2'd0);
        step(); chk4("rr5", 1'b1, 4'b0010, 2'd1, 2'd1);

        // grant held while not ready, even after the request drops
        rdy4 = 1'b0;
        req4 = 4'b0000;
        do_reset();
        req4 = 4'b0100;
        step(); chk4("hold0", 1'b1, 4'b0100, 2'd2, 2'd0);
        for (int c = 0; c < 3; c++) begin
            step(); chk4("hold", 1'b1, 4'b0100, 2'd2, 2'd0);
        end
        req4 = 4'b0000;
        step(); chk4("holddrop", 1'b1, 4'b0100, 2'd2, 2'd0);
        rdy4 = 1'b1;
        step(); chk4("release", 1'b0, 4'b0000, 2'd0, 2'd3);
        rdy4 = 1'b0;
        step(); chk4("idleptr", 1'b0, 4'b0000, 2'd0, 2'd3);

        // pointer at 3 with only low requests: wrap to 0, then rotate
        req4 = 4'b0011;
        step(); chk4("wrap0", 1'b1, 4'b0001, 2'd0, 2'd3);
        rdy4 = 1'b1;
        step(); chk4("wrap1", 1'b1, 4'b0010, 2'd1, 2'd1);
        step(); chk4("wrap2", 1'b1, 4'b0001, 2'd0, 2'd2);

        // move to a grant of idx 2 with ptr 1, then reset asynchronously
        req4 = 4'b0100;
        step(); chk4("pre_rst", 1'b1, 4'b0100, 2'd2, 2'd1);
        rdy4 = 1'b0;
        #2 rst = 1'b1;
        #1 chk4("async_rst", 1'b0, 4'b0000, 2'd0, 2'd0);
        check("async_rst.idx", {30'd0, idx4}, 32'd0);
        step();
        rst = 1'b0;
        chk4("rst_rel", 1'b0, 4'b0000, 2'd0, 2'd0);
        step(); chk4("post_rst", 1'b1, 4'b0100, 2'd2, 2'd0);
        req4 = 4'b0000;

        // five requesters: 0 and 4 alternate, pointer wraps 4 -> 0
        do_reset();
        req5 = 5'b10001;
        rdy5 = 1'b1;
        step();
        check("n5.g0.idx", {29'd0, idx5}, 32'd0);
        check("n5.g0.gnt", {27'd0, gnt5}, 32'b00001);
        check("n5.g0.ptr", {29'd0, ptr5}, 32'd0);
        step();
        check("n5.g1.idx", {29'd0, idx5}, 32'd4);
        check("n5.g1.gnt", {27'd0, gnt5}, 32'b10000);
        check("n5.g1.ptr", {29'd0, ptr5}, 32'd1);
        step();
        check("n5.g2.idx", {29'd0, idx5}, 32'd0);
        check("n5.g2.ptr", {29'd0, ptr5}, 32'd0);
        step();
        check("n5.g3.idx", {29'd0, idx5}, 32'd4);
        check("n5.g3.ptr", {29'd0, ptr5}, 32'd1);
        check("n5.g3.valid", {31'd0, vld5}, 32'd1);
        req5 = 5'b00000;
        step();
        check("n5.idle.valid", {31'd0, vld5}, 32'd0);
        check("n5.idle.ptr", {29'd0, ptr5}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
